// File: rtl/caesar_clk_gate_ctrl.sv
// rtl/caesar_clk_gate_ctrl.sv - multi-channel clock-gating controller with idle auto-gating and wake handshake
module caesar_clk_gate_ctrl #(
  parameter int NCH      = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scan_cg_en_i,
  input  logic [IDLE_W-1:0] cfg_idle_thr_i,
  input  logic [NCH-1:0]    cfg_auto_en_i,
  input  logic [NCH-1:0]    sw_en_i,
  input  logic [NCH-1:0]    busy_i,
  input  logic [NCH-1:0]    wake_req_i,
  output logic [NCH-1:0]    wake_ack_o,
  output logic [NCH-1:0]    gated_o,
  output logic [NCH-1:0]    clk_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_GATED = 2'd1;
  localparam logic [1:0] ST_WAKE  = 2'd2;

  localparam int WW = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WW-1:0]     WAKE_LAST = WW'(WAKE_LAT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = {IDLE_W{1'b1}};

  // A zero threshold behaves like one; compare one bit wider so idle+1 cannot wrap.
  logic [IDLE_W:0] thr_eff;
  assign thr_eff = (cfg_idle_thr_i == '0) ? (IDLE_W+1)'(1) : {1'b0, cfg_idle_thr_i};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [1:0]        state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WW-1:0]     wake_q, wake_d;
    logic [IDLE_W:0]   idle_inc;
    logic              act;
    logic              en_q;
    logic              lat;

    assign act      = busy_i[c] | sw_en_i[c] | wake_req_i[c];
    assign idle_inc = {1'b0, idle_q} + (IDLE_W+1)'(1);

    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      case (state_q)
        ST_RUN: begin
          if (act) begin
            idle_d = '0;
          end else if (cfg_auto_en_i[c] && (idle_inc >= thr_eff)) begin
            state_d = ST_GATED;
            idle_d  = '0;
          end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_inc[IDLE_W-1:0];
          end
        end
        ST_GATED: begin
          if (act || !cfg_auto_en_i[c]) begin
            state_d = ST_WAKE;
            wake_d  = '0;
          end
        end
        ST_WAKE: begin
          if (wake_q == WAKE_LAST) begin
            state_d = ST_RUN;
            idle_d  = '0;
          end else begin
            wake_d = wake_q + WW'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= ST_RUN;
        idle_q  <= '0;
        wake_q  <= '0;
        en_q    <= 1'b1;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        wake_q  <= wake_d;
        en_q    <= (state_d != ST_GATED);
      end
    end

    // Low-phase latch keeps enable changes away from the high phase of clk_o.
    always_latch begin
      if (!clk_i) lat = en_q | scan_cg_en_i;
    end

    assign clk_o[c]      = clk_i & lat;
    assign wake_ack_o[c] = (state_q == ST_RUN);
    assign gated_o[c]    = (state_q == ST_GATED);
  end

endmodule
